// File: rtl/snake_tick_input.sv
`default_nettype none
// ============================================================================
// Module      : snake_tick_input
// Description : Debounced turn-key press pulses and a speed-scaled move tick
//               for the snake game. Allows at most one turn per move period.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_tick_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_BASE       = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_right_n,
    input  logic       key_left_n,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic       go_right,
    output logic       go_left,
    output logic       trigger
);

    localparam logic [19:0] c_deb_last  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] c_tick_base = 24'(TICK_BASE);

    logic [1:0]  w_key_n;
    logic [1:0]  w_press;
    logic [23:0] w_reload;
    logic        w_lock_free;
    logic [23:0] r_tick_cnt;
    logic        r_lock;

    // Index 0 is the right key, index 1 the left key; keys are active-low.
    assign w_key_n  = {key_left_n, key_right_n};
    assign w_reload = (c_tick_base >> speed) - 24'd1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic        r_sync1;
            logic        r_sync2;
            logic        r_stable;
            logic        r_stable_d;
            logic [19:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1    <= 1'b1;
                    r_sync2    <= 1'b1;
                    r_stable   <= 1'b1;
                    r_stable_d <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_key_n[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_deb_last) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
            end

            // Only the released-to-pressed transition counts as an event.
            assign w_press[gi] = r_stable_d & ~r_stable;
        end
    endgenerate

    // The trigger cycle itself re-opens the turn window.
    assign w_lock_free = ~r_lock | trigger;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= w_reload;
            r_lock     <= 1'b0;
            trigger    <= 1'b0;
            go_right   <= 1'b0;
            go_left    <= 1'b0;
        end else if (pause) begin
            trigger  <= 1'b0;
            go_right <= 1'b0;
            go_left  <= 1'b0;
            r_lock   <= r_lock & ~trigger;
        end else begin
            trigger    <= (r_tick_cnt == 24'd0);
            r_tick_cnt <= (r_tick_cnt == 24'd0) ? w_reload : r_tick_cnt - 24'd1;
            go_right   <= w_press[0] & w_lock_free;
            go_left    <= w_press[1] & ~w_press[0] & w_lock_free;
            r_lock     <= ((|w_press) & w_lock_free) | (r_lock & ~trigger);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snake_tick_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_tick_input
// Description : Directed bench for snake_tick_input (DEBOUNCE_CYCLES=4,
//               TICK_BASE=32). Cycle n is the interval after the n-th edge
//               following reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_tick_input;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_right_n;
    logic       key_left_n;
    logic [1:0] speed;
    logic       pause;
    logic       go_right;
    logic       go_left;
    logic       trigger;

    int n_checks = 0;
    int n_fail   = 0;

    snake_tick_input #(
        .DEBOUNCE_CYCLES(4),
        .TICK_BASE      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_right_n(key_right_n),
        .key_left_n (key_left_n),
        .speed      (speed),
        .pause      (pause),
        .go_right   (go_right),
        .go_left    (go_left),
        .trigger    (trigger)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [1:0] s);
        reset       = 1'b1;
        key_right_n = 1'b1;
        key_left_n  = 1'b1;
        pause       = 1'b0;
        speed       = s;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        key_right_n = 1'b0;
        key_left_n  = 1'b0;
        pause       = 1'b0;
        speed       = 2'd0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (n >= 1) begin
                n_checks++;
                if ({go_right, go_left, trigger} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL reset_outputs cycle %0d: {go_right,go_left,trigger}=%b expected 000",
                             n, {go_right, go_left, trigger});
                end
            end
        end
    endtask

    task automatic test_tick();
        logic exp;
        do_reset(2'd0);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            exp = (n == 31) || (n == 63) || (n == 95);
            n_checks++;
            if (trigger !== exp) begin
                n_fail++;
                $display("FAIL tick_speed0 cycle %0d: trigger=%b expected %b", n, trigger, exp);
            end
        end
        do_reset(2'd2);
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            exp = ((n % 8) == 7);
            n_checks++;
            if (trigger !== exp) begin
                n_fail++;
                $display("FAIL tick_speed2 cycle %0d: trigger=%b expected %b", n, trigger, exp);
            end
        end
    endtask

    task automatic test_speed_change();
        logic exp;
        do_reset(2'd0);
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            exp = (n == 31) || (n == 39) || (n == 47) || (n == 55);
            n_checks++;
            if (trigger !== exp) begin
                n_fail++;
                $display("FAIL speed_change cycle %0d: trigger=%b expected %b", n, trigger, exp);
            end
            if (n == 10) speed = 2'd2;
        end
    endtask

    task automatic test_press();
        logic exp;
        do_reset(2'd0);
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            exp = (n == 7);
            n_checks++;
            if ({go_right, go_left} !== {exp, 1'b0}) begin
                n_fail++;
                $display("FAIL press_right cycle %0d: {go_right,go_left}=%b expected %b",
                         n, {go_right, go_left}, {exp, 1'b0});
            end
            if (n == 0)  key_right_n = 1'b0;
            if (n == 20) key_right_n = 1'b1;
        end
    endtask

    task automatic test_glitch(input int len, input bit pulse);
        logic exp;
        do_reset(2'd0);
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            exp = pulse && (n == 7);
            n_checks++;
            if (go_right !== exp) begin
                n_fail++;
                $display("FAIL glitch_len%0d cycle %0d: go_right=%b expected %b", len, n, go_right, exp);
            end
            if (n == 0)   key_right_n = 1'b0;
            if (n == len) key_right_n = 1'b1;
        end
    endtask

    task automatic test_lock();
        logic exp;
        do_reset(2'd0);
        for (int n = 0; n < 46; n++) begin
            @(posedge clk); #1;
            exp = (n == 7) || (n == 39);
            n_checks++;
            if (go_right !== exp) begin
                n_fail++;
                $display("FAIL lock cycle %0d: go_right=%b expected %b", n, go_right, exp);
            end
            if (n == 0 || n == 14 || n == 32) key_right_n = 1'b0;
            if (n == 6 || n == 20 || n == 38) key_right_n = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        do_reset(2'd0);
        for (int n = 0; n < 62; n++) begin
            @(posedge clk); #1;
            exp = (n == 7) || (n == 32);
            n_checks++;
            if (go_right !== exp) begin
                n_fail++;
                $display("FAIL press_at_trigger cycle %0d: go_right=%b expected %b", n, go_right, exp);
            end
            if (n == 0 || n == 25 || n == 40) key_right_n = 1'b0;
            if (n == 6 || n == 31 || n == 46) key_right_n = 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        logic exp_r;
        logic exp_l;
        do_reset(2'd0);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            exp_r = (n == 7);
            exp_l = (n == 40);
            n_checks++;
            if ({go_right, go_left} !== {exp_r, exp_l}) begin
                n_fail++;
                $display("FAIL simultaneous cycle %0d: {go_right,go_left}=%b expected %b",
                         n, {go_right, go_left}, {exp_r, exp_l});
            end
            if (n == 0) begin
                key_right_n = 1'b0;
                key_left_n  = 1'b0;
            end
            if (n == 6) begin
                key_right_n = 1'b1;
                key_left_n  = 1'b1;
            end
            if (n == 13 || n == 33) key_left_n = 1'b0;
            if (n == 19 || n == 39) key_left_n = 1'b1;
        end
    endtask

    task automatic test_pause();
        logic exp;
        do_reset(2'd0);
        for (int n = 0; n < 116; n++) begin
            @(posedge clk); #1;
            exp = (n == 81) || (n == 113);
            n_checks++;
            if ({trigger, go_right} !== {exp, 1'b0}) begin
                n_fail++;
                $display("FAIL pause cycle %0d: {trigger,go_right}=%b expected %b",
                         n, {trigger, go_right}, {exp, 1'b0});
            end
            if (n == 9)  pause = 1'b1;
            if (n == 59) pause = 1'b0;
            if (n == 12 || n == 50) key_right_n = 1'b0;
            if (n == 18 || n == 70) key_right_n = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        do_reset(2'd0);
        for (int m = 0; m < 72; m++) begin
            @(posedge clk); #1;
            exp = (m == 62);
            n_checks++;
            if ({trigger, go_right} !== {exp, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: {trigger,go_right}=%b expected %b",
                         m, {trigger, go_right}, {exp, 1'b0});
            end
            if (m == 23) key_right_n = 1'b0;
            if (m == 28) begin
                reset       = 1'b1;
                key_right_n = 1'b1;
            end
            if (m == 30) reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_speed_change();
        test_press();
        test_glitch(3, 1'b0);
        test_glitch(4, 1'b1);
        test_lock();
        test_back_to_back();
        test_simultaneous();
        test_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_tick_input.md
SNAKE_TICK_INPUT -- requirements
Module: snake_tick_input

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable samples needed to accept a key change; legal range 1..2^20-1.
REQ-002 The block SHALL have the parameter TICK_BASE, default 12500000, meaning the move period in clocks at speed 0; legal range 8..2^24-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port key_right_n, input, 1 bit: raw, asynchronous, active-low right-turn pushbutton.
REQ-006 The block SHALL have port key_left_n, input, 1 bit: raw, asynchronous, active-low left-turn pushbutton.
REQ-007 The block SHALL have port speed, input, 2 bits: speed level; move period = TICK_BASE >> speed.
REQ-008 The block SHALL have port pause, input, 1 bit: while high, the tick countdown freezes and turns are suppressed.
REQ-009 The block SHALL have port go_right, output, 1 bit: one-cycle right-turn pulse for the direction FSM.
REQ-010 The block SHALL have port go_left, output, 1 bit: one-cycle left-turn pulse for the direction FSM.
REQ-011 The block SHALL have port trigger, output, 1 bit: one-cycle pulse that starts one erase/move/shift sequence in the snake datapath.

Function
REQ-012 Each key SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each key SHALL have its own debounce counter (20 bits) and stable-state register; the register starts at released.
REQ-014 The debounce counter SHALL increment each cycle the synchronized value differs from the stable state and SHALL clear to 0 on any cycle they match.
REQ-015 When the debounce counter equals DEBOUNCE_CYCLES-1 and the values still differ, the stable state SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-016 A press event SHALL be the stable state changing from released to pressed; release events SHALL produce no output.
REQ-017 Latency: a key held low from cycle 0 SHALL produce its go pulse in cycle DEBOUNCE_CYCLES+3, high for exactly one cycle.
REQ-018 A turn-lock flag SHALL allow at most one accepted turn per move period; an accepted press sets the lock, and later presses are dropped without queuing until the lock clears.
REQ-019 If right and left press events occur in the same cycle, only go_right SHALL pulse, and the lock SHALL set.
REQ-020 The tick counter (24 bits) SHALL decrement by 1 each unpaused cycle; when it is 0 it SHALL assert trigger for that cycle and reload with (TICK_BASE >> speed) - 1, sampling speed at reload.
REQ-021 A change of speed SHALL take effect only at the next reload; the period in progress is not shortened.
REQ-022 Trigger SHALL clear the turn lock; a press event in the same cycle as trigger SHALL be accepted and SHALL leave the lock set.
REQ-023 While pause is high, the tick counter SHALL hold, trigger and both go outputs SHALL be 0, and press events SHALL be discarded (not deferred).
REQ-024 While pause is high, debouncing SHALL continue, so a key held through un-pause produces no pulse.
REQ-025 On un-pause, the countdown SHALL resume from the held value.
REQ-026 go_right, go_left and trigger SHALL be registered outputs with no combinational path from any input.

Reset
REQ-027 While reset is high at a clock edge, all outputs SHALL be 0 the following cycle.
REQ-028 On reset, the synchronizers and stable states SHALL be set to released and the debounce counters and turn lock to 0.
REQ-029 On reset, the tick counter SHALL load (TICK_BASE >> speed) - 1.
REQ-030 Reset asserted mid-debounce or mid-period SHALL abandon that progress, and no pulse SHALL be emitted for a press begun before reset.

Verification (DEBOUNCE_CYCLES=4, TICK_BASE=32)
REQ-031 Tick: hold speed=0, pause=0 after reset, and keys idle -> trigger is high in cycles 31, 63, 95 only; with speed=2 -> the period is 8.
REQ-032 Press: key_right_n low from cycle 0 for 20 cycles -> go_right is high in cycle 7 only; a 3-cycle glitch -> no pulse.
REQ-033 Lock: two clean right presses within one period -> one go_right pulse; a press after the next trigger -> a second pulse.
REQ-034 Simultaneous: both keys low in the same cycle -> go_right pulses and go_left stays 0 for the whole period.
REQ-035 Pause: pause high for 50 cycles mid-period with a key pressed -> no trigger and no go pulse; after un-pause, trigger arrives after the remaining count.
REQ-036 Reset: reset asserted 2 cycles before a pending go pulse and a pending trigger -> neither pulse appears, and the first trigger comes 32 cycles after reset deasserts.
